regfile_access_arbiter: RTL and testbench

- Shares the single mode-switched port of the 32-entry x 32-bit register file between two requesters (e.g. fetch/decode side and writeback side).
- Arbitrates round-robin and sequences each access safely into the level-sensitive register file: address/data set up before the write strobe, held after it, and read data captured after a settle wait.
- Sits between the requesters and the register file instance; it is the only driver of the file's mode/address/data inputs.

---
 rtl/regfile_access_arbiter_pkg.sv | 20 ++
 rtl/regfile_access_arbiter_rr_arbiter2.sv | 18 +
 rtl/regfile_access_arbiter.sv | 141 ++++++++++++++
 tb/tb_regfile_access_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_access_arbiter_pkg.sv
// Shared types and constants for the register-file access arbiter.
// Holds the sequencer state encoding and the register-file mode values.
package regfile_access_arbiter_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    localparam logic RF_MODE_READ  = 1'b0;
    localparam logic RF_MODE_WRITE = 1'b1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        W_SETUP  = 3'd1,
        W_STROBE = 3'd2,
        W_HOLD   = 3'd3,
        R_WAIT   = 3'd4,
        RESP     = 3'd5
    } arbState_e;

endpackage

// File: rtl/regfile_access_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: on a tie the requester other than the last winner is chosen.
// Purely combinational; the last pointer is owned by the caller.
module regfile_access_arbiter_rr_arbiter2 (
    input  logic valid0,
    input  logic valid1,
    input  logic last,
    output logic grant0,
    output logic grant1,
    output logic grantId
);

    always_comb begin
        grant0  = valid0 & (~valid1 | last);
        grant1  = valid1 & (~valid0 | ~last);
        grantId = grant1;
    end

endmodule

// File: rtl/regfile_access_arbiter.sv
// Arbitrates two requesters onto the single mode-switched register-file port and
// sequences each access: write setup/strobe/hold, or read address settle then capture.
module regfile_access_arbiter
    import regfile_access_arbiter_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int READ_WAIT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              resp0_valid,
    output logic [DATA_W-1:0] resp0_rdata,
    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              resp1_valid,
    output logic [DATA_W-1:0] resp1_rdata,
    output logic              rf_mode,
    output logic [ADDR_W-1:0] rf_write_addr,
    output logic [DATA_W-1:0] rf_write_value,
    output logic [ADDR_W-1:0] rf_read_addr,
    input  logic [DATA_W-1:0] rf_read_value,
    output logic              busy,
    output logic              grant_id
);

    localparam int CNT_W = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(READ_WAIT - 1);

    arbState_e         state;
    arbState_e         stateNext;
    logic [CNT_W-1:0]  waitCnt;
    logic [CNT_W-1:0]  waitCntNext;
    logic              last;
    logic              grant0;
    logic              grant1;
    logic              arbId;
    logic              idle;
    logic              accept;
    logic              acceptWrite;
    logic [ADDR_W-1:0] acceptAddr;
    logic [DATA_W-1:0] acceptData;
    logic              enterResp;
    logic [DATA_W-1:0] capValue;

    regfile_access_arbiter_rr_arbiter2 uArb (
        .valid0  (req0_valid),
        .valid1  (req1_valid),
        .last    (last),
        .grant0  (grant0),
        .grant1  (grant1),
        .grantId (arbId)
    );

    // Ready is decoded from the registered state so a handshake completes in the same cycle.
    assign idle        = (state == IDLE);
    assign req0_ready  = idle & grant0;
    assign req1_ready  = idle & grant1;
    assign accept      = idle & (grant0 | grant1);
    assign acceptWrite = arbId ? req1_write : req0_write;
    assign acceptAddr  = arbId ? req1_addr  : req0_addr;
    assign acceptData  = arbId ? req1_wdata : req0_wdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            waitCnt <= '0;
        end else begin
            state   <= stateNext;
            waitCnt <= waitCntNext;
        end
    end

    always_comb begin
        stateNext   = state;
        waitCntNext = waitCnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    stateNext   = acceptWrite ? W_SETUP : R_WAIT;
                    waitCntNext = '0;
                end
            end
            W_SETUP:  stateNext = W_STROBE;
            W_STROBE: stateNext = W_HOLD;
            W_HOLD:   stateNext = RESP;
            R_WAIT: begin
                if (waitCnt == WAIT_LAST) stateNext = RESP;
                else                      waitCntNext = waitCnt + 1'b1;
            end
            RESP:     stateNext = IDLE;
            default:  stateNext = IDLE;
        endcase
    end

    // Read data is sampled on the edge leaving the final settle cycle; writes report zero.
    assign enterResp = (stateNext == RESP);
    assign capValue  = (state == R_WAIT) ? rf_read_value : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last           <= 1'b1;
            grant_id       <= 1'b0;
            busy           <= 1'b0;
            rf_mode        <= RF_MODE_READ;
            rf_write_addr  <= '0;
            rf_write_value <= '0;
            rf_read_addr   <= '0;
            resp0_valid    <= 1'b0;
            resp1_valid    <= 1'b0;
            resp0_rdata    <= '0;
            resp1_rdata    <= '0;
        end else begin
            busy        <= (stateNext != IDLE);
            rf_mode     <= (stateNext == W_STROBE) ? RF_MODE_WRITE : RF_MODE_READ;
            resp0_valid <= enterResp & ~grant_id;
            resp1_valid <= enterResp & grant_id;
            resp0_rdata <= (enterResp & ~grant_id) ? capValue : '0;
            resp1_rdata <= (enterResp & grant_id)  ? capValue : '0;
            if (accept) begin
                last     <= arbId;
                grant_id <= arbId;
                if (acceptWrite) begin
                    rf_write_addr  <= acceptAddr;
                    rf_write_value <= acceptData;
                end else begin
                    rf_read_addr   <= acceptAddr;
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_access_arbiter.sv
// Self-checking bench: a register-file model, a scoreboard of expected responses
// and a reference round-robin model drive and check the arbiter.
module tb_regfile_access_arbiter;

    localparam int RW = 1;

    typedef struct {
        logic        write;
        logic [4:0]  addr;
        logic [31:0] data;
    } opT;

    typedef struct {
        logic        id;
        logic [31:0] data;
        int          acc;
        int          lat;
        logic        write;
        logic [4:0]  addr;
        logic [31:0] wdata;
    } expT;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req0_valid = 1'b0, req0_write = 1'b0;
    logic [4:0]  req0_addr = '0;
    logic [31:0] req0_wdata = '0;
    logic        req0_ready, resp0_valid;
    logic [31:0] resp0_rdata;
    logic        req1_valid = 1'b0, req1_write = 1'b0;
    logic [4:0]  req1_addr = '0;
    logic [31:0] req1_wdata = '0;
    logic        req1_ready, resp1_valid;
    logic [31:0] resp1_rdata;
    logic        rf_mode, busy, grant_id;
    logic [4:0]  rf_write_addr, rf_read_addr;
    logic [31:0] rf_write_value, rf_read_value;

    logic        bReq0Valid = 1'b0, bReq0Write = 1'b0;
    logic [4:0]  bReq0Addr = '0;
    logic [31:0] bReq0Wdata = '0;
    logic        bReq0Ready, bResp0Valid;
    logic [31:0] bResp0Rdata;
    logic        bReq1Valid = 1'b0, bReq1Write = 1'b0;
    logic [4:0]  bReq1Addr = '0;
    logic [31:0] bReq1Wdata = '0;
    logic        bReq1Ready, bResp1Valid;
    logic [31:0] bResp1Rdata;
    logic        bRfMode, bBusy, bGrantId;
    logic [4:0]  bRfWriteAddr, bRfReadAddr;
    logic [31:0] bRfWriteValue, bRfReadValue;

    logic [31:0] rfMem [32];
    logic [31:0] model [32];
    opT          q0[$];
    opT          q1[$];
    expT         expQ[$];
    logic        grants[$];
    logic        lastM = 1'b1;
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;

    logic        shValid = 1'b0;
    logic        shMode = 1'b0;
    logic [4:0]  shAddr = '0;
    logic [31:0] shVal = '0;
    logic        expG [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    always #5 clk = ~clk;

    regfile_access_arbiter #(.DATA_W(32), .ADDR_W(5), .READ_WAIT(RW)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready), .resp0_valid(resp0_valid),
        .resp0_rdata(resp0_rdata),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready), .resp1_valid(resp1_valid),
        .resp1_rdata(resp1_rdata),
        .rf_mode(rf_mode), .rf_write_addr(rf_write_addr), .rf_write_value(rf_write_value),
        .rf_read_addr(rf_read_addr), .rf_read_value(rf_read_value),
        .busy(busy), .grant_id(grant_id)
    );

    regfile_access_arbiter #(.DATA_W(32), .ADDR_W(5), .READ_WAIT(3)) dut3 (
        .clk(clk), .reset(reset),
        .req0_valid(bReq0Valid), .req0_write(bReq0Write), .req0_addr(bReq0Addr),
        .req0_wdata(bReq0Wdata), .req0_ready(bReq0Ready), .resp0_valid(bResp0Valid),
        .resp0_rdata(bResp0Rdata),
        .req1_valid(bReq1Valid), .req1_write(bReq1Write), .req1_addr(bReq1Addr),
        .req1_wdata(bReq1Wdata), .req1_ready(bReq1Ready), .resp1_valid(bResp1Valid),
        .resp1_rdata(bResp1Rdata),
        .rf_mode(bRfMode), .rf_write_addr(bRfWriteAddr), .rf_write_value(bRfWriteValue),
        .rf_read_addr(bRfReadAddr), .rf_read_value(bRfReadValue),
        .busy(bBusy), .grant_id(bGrantId)
    );

    // Register file seen by the main instance; the READ_WAIT=3 instance reads a fixed pattern.
    always @(posedge clk) if (rf_mode) rfMem[rf_write_addr] <= rf_write_value;
    assign rf_read_value = rfMem[rf_read_addr];
    assign bRfReadValue  = 32'hC0DE0000 | {27'd0, bRfReadAddr};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Write address/data must not move while the strobe is high or across its edges.
    always @(negedge clk) begin
        #2;
        if (!reset) begin
            shValid <= 1'b0;
        end else begin
            if (shValid && (rf_mode || shMode)) begin
                chk("hold_waddr", {27'd0, rf_write_addr}, {27'd0, shAddr});
                chk("hold_wdata", rf_write_value, shVal);
            end
            shValid <= 1'b1;
            shMode  <= rf_mode;
            shAddr  <= rf_write_addr;
            shVal   <= rf_write_value;
        end
    end

    function automatic opT mkOp(input logic w, input logic [4:0] a, input logic [31:0] d);
        opT o;
        o.write = w;
        o.addr  = a;
        o.data  = d;
        return o;
    endfunction

    task automatic serve(input int budget);
        int n;
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || expQ.size() > 0) && n < budget) begin
            expT e;
            opT  o;
            int  d;
            logic v0, v1, w, accId;
            @(negedge clk);
            cyc++;
            n++;
            v0 = (q0.size() > 0);
            v1 = (q1.size() > 0);
            req0_valid = v0;
            req1_valid = v1;
            if (v0) begin req0_write = q0[0].write; req0_addr = q0[0].addr; req0_wdata = q0[0].data; end
            if (v1) begin req1_write = q1[0].write; req1_addr = q1[0].addr; req1_wdata = q1[0].data; end
            #1;
            if (expQ.size() > 0) begin
                e = expQ[0];
                d = cyc - e.acc;
                chk("busy_active", {31'd0, busy}, 32'd1);
                chk("grant_id", {31'd0, grant_id}, {31'd0, e.id});
                chk("ready_while_busy", {30'd0, req1_ready, req0_ready}, 32'd0);
                if (e.write && d < 4) begin
                    chk("wr_mode", {31'd0, rf_mode}, {31'd0, (d == 2)});
                    chk("wr_addr", {27'd0, rf_write_addr}, {27'd0, e.addr});
                    chk("wr_value", rf_write_value, e.wdata);
                end else if (!e.write && d <= RW) begin
                    chk("rd_mode", {31'd0, rf_mode}, 32'd0);
                    chk("rd_addr", {27'd0, rf_read_addr}, {27'd0, e.addr});
                end
                if (d == e.lat) begin
                    chk("resp_valid", {30'd0, resp1_valid, resp0_valid}, e.id ? 32'd2 : 32'd1);
                    chk("resp_rdata", e.id ? resp1_rdata : resp0_rdata, e.data);
                    void'(expQ.pop_front());
                end else begin
                    chk("resp_early", {30'd0, resp1_valid, resp0_valid}, 32'd0);
                end
            end else begin
                chk("busy_idle", {31'd0, busy}, 32'd0);
                chk("resp_idle", {30'd0, resp1_valid, resp0_valid}, 32'd0);
                w = (v0 && v1) ? ~lastM : v1;
                chk("ready0", {31'd0, req0_ready}, {31'd0, (v0 && !w)});
                chk("ready1", {31'd0, req1_ready}, {31'd0, (v1 && w)});
                if (req0_ready || req1_ready) begin
                    accId = req1_ready;
                    if (accId) o = q1.pop_front();
                    else       o = q0.pop_front();
                    e.id    = accId;
                    e.acc   = cyc;
                    e.write = o.write;
                    e.addr  = o.addr;
                    e.wdata = o.data;
                    e.lat   = o.write ? 4 : RW + 1;
                    e.data  = o.write ? 32'd0 : model[o.addr];
                    if (o.write) model[o.addr] = o.data;
                    expQ.push_back(e);
                    grants.push_back(accId);
                    if (v0 || v1) lastM = w;
                end
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        if (q0.size() > 0 || q1.size() > 0 || expQ.size() > 0) begin
            vectors++;
            miscompares++;
            $error("FAIL serve_timeout pending=%0d expected=0", q0.size() + q1.size() + expQ.size());
            q0.delete(); q1.delete(); expQ.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 32; i++) begin rfMem[i] = '0; model[i] = '0; end
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_mode", {31'd0, rf_mode}, 32'd0);
        chk("rst_grant", {31'd0, grant_id}, 32'd0);
        chk("rst_resp", {30'd0, resp1_valid, resp0_valid}, 32'd0);
        chk("rst_addrs", {22'd0, rf_write_addr, rf_read_addr}, 32'd0);
        chk("rst_wvalue", rf_write_value, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        lastM = 1'b1;

        // Simultaneous requests straight out of reset
        q0.push_back(mkOp(1'b1, 5'd1, 32'hA5A5A5A5));
        q1.push_back(mkOp(1'b0, 5'd1, 32'h0));
        serve(60);
        chk("sim_count", grants.size(), 32'd2);
        chk("sim_first", {31'd0, grants[0]}, 32'd0);
        chk("sim_second", {31'd0, grants[1]}, 32'd1);

        // Fairness with both requesters continuously valid
        grants.delete();
        q0.push_back(mkOp(1'b1, 5'd3, 32'h11111111));
        q1.push_back(mkOp(1'b0, 5'd3, 32'h0));
        q0.push_back(mkOp(1'b1, 5'd4, 32'h44444444));
        q1.push_back(mkOp(1'b1, 5'd3, 32'h22222222));
        q0.push_back(mkOp(1'b0, 5'd3, 32'h0));
        q1.push_back(mkOp(1'b0, 5'd4, 32'h0));
        serve(120);
        chk("fair_count", grants.size(), 32'd6);
        for (int i = 0; i < 6; i++) chk("fair_grant", {31'd0, grants[i]}, {31'd0, expG[i]});

        // Single write then read on requester 0
        q0.push_back(mkOp(1'b1, 5'd0, 32'h12345678));
        q0.push_back(mkOp(1'b0, 5'd0, 32'h0));
        serve(60);

        // Extreme index and data patterns with readback
        q0.push_back(mkOp(1'b1, 5'd31, 32'hFFFFFFFF));
        q0.push_back(mkOp(1'b1, 5'd2, 32'h00000001));
        q1.push_back(mkOp(1'b0, 5'd31, 32'h0));
        q1.push_back(mkOp(1'b0, 5'd2, 32'h0));
        serve(120);

        // Reset asserted during the write strobe
        @(negedge clk);
        req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 5'd7; req0_wdata = 32'hDEADBEEF;
        #1;
        chk("mid_ready", {31'd0, req0_ready}, 32'd1);
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        chk("mid_setup_mode", {31'd0, rf_mode}, 32'd0);
        @(negedge clk);
        #1;
        chk("mid_strobe_mode", {31'd0, rf_mode}, 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_mode", {31'd0, rf_mode}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk("mid_no_resp", {30'd0, resp1_valid, resp0_valid}, 32'd0);
        end
        @(negedge clk);
        reset = 1'b1;
        lastM = 1'b1;
        grants.delete();
        q0.push_back(mkOp(1'b1, 5'd9, 32'h09090909));
        q1.push_back(mkOp(1'b1, 5'd10, 32'h10101010));
        q0.push_back(mkOp(1'b0, 5'd10, 32'h0));
        serve(80);
        chk("post_rst_first", {31'd0, grants[0]}, 32'd0);

        // READ_WAIT=3 instance: address held three cycles, response on the fourth
        @(negedge clk);
        bReq0Valid = 1'b1; bReq0Write = 1'b0; bReq0Addr = 5'd5;
        #1;
        chk("rw3_ready", {31'd0, bReq0Ready}, 32'd1);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            bReq0Valid = 1'b0;
            #1;
            if (k < 4) begin
                chk("rw3_addr", {27'd0, bRfReadAddr}, 32'd5);
                chk("rw3_no_resp", {31'd0, bResp0Valid}, 32'd0);
            end else begin
                chk("rw3_resp", {31'd0, bResp0Valid}, 32'd1);
                chk("rw3_rdata", bResp0Rdata, 32'hC0DE0005);
            end
        end
        @(negedge clk);
        #1;
        chk("rw3_idle", {31'd0, bBusy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
